// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the IF/LS memory bus arbiter: response tags and arbitration states.
package mem_bus_arbiter_pkg;

    localparam int unsigned TagW    = 2;
    localparam int unsigned StarveW = 4;

    // Tag carried alongside each RAM access to route the read response.
    typedef enum logic [TagW-1:0] {
        TagNone = 2'd0,
        TagIf   = 2'd1,
        TagLs   = 2'd2
    } tag_e;

    typedef enum logic [0:0] {
        StLsPrio  = 1'b0,
        StIfForce = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_tag_pipe.sv
// Depth-stage shift register of response tags; a flush rewrites every IF tag
// (including the one entering this cycle) to NONE.
module mem_bus_arbiter_tag_pipe
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [TagW-1:0] tag_in,
    output logic [TagW-1:0] tag_out
);

    tag_e tag_q [Depth];
    tag_e tag_d [Depth];

    // Next stage contents: shift by one, squashing IF tags on flush.
    always_comb begin
        tag_d[0] = (flush && tag_e'(tag_in) == TagIf) ? TagNone : tag_e'(tag_in);
        for (int i = 1; i < int'(Depth); i++) begin
            tag_d[i] = (flush && tag_q[i-1] == TagIf) ? TagNone : tag_q[i-1];
        end
    end

    // Tag registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) tag_q[i] <= TagNone;
        end else begin
            for (int i = 0; i < int'(Depth); i++) tag_q[i] <= tag_d[i];
        end
    end

    assign tag_out = tag_q[Depth-1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one pipelined single-port RAM between instruction fetch (IF) and
// load/store (LS). LS has priority; after STARVE_MAX consecutive LS grants with IF
// waiting, one IF grant is forced. Read responses are routed back by tag.
// Optional macro ARB_PERF_CNT_EN adds the perf_if_stall / perf_ls_gnt counters;
// without it both perf ports are tied to zero.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvld,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvld,
    output logic [31:0] ls_rdata,
    input  logic        flush,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        hold_IF,
    output logic        hold_EX,
    output logic [31:0] perf_if_stall,
    output logic [31:0] perf_ls_gnt
);

    arb_state_e         state_q, state_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic [StarveW-1:0] starve_inc;
    logic [TagW-1:0]    push_tag;
    logic [TagW-1:0]    out_tag;

    assign starve_inc = starve_q + 1'b1;

    // Arbitration: grant decision plus next state and starvation counter.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if_gnt   = 1'b0;
        ls_gnt   = 1'b0;

        unique case (state_q)
            StLsPrio: begin
                if (ls_req) begin
                    ls_gnt = 1'b1;
                end else if (if_req) begin
                    if_gnt = 1'b1;
                end
            end
            StIfForce: begin
                if (if_req) begin
                    if_gnt = 1'b1;
                end else if (ls_req) begin
                    ls_gnt = 1'b1;
                end
            end
            default: ;
        endcase

        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (ls_gnt) begin
            starve_d = starve_inc;
        end

        // Forced IF lasts one grant, or ends early if the fetch goes away.
        if (if_gnt || !if_req) begin
            state_d = StLsPrio;
        end else if (state_q == StLsPrio && ls_gnt && starve_inc == StarveW'(STARVE_MAX)) begin
            state_d = StIfForce;
        end
    end

    // Arbitration state and starvation counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StLsPrio;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // RAM strobe and payload mux; all fields zero when idle.
    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (if_gnt) begin
            mem_cs   = 1'b1;
            mem_be   = 4'hF;
            mem_addr = if_addr;
        end else if (ls_gnt) begin
            mem_cs    = 1'b1;
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end
    end

    // Stores return nothing, so they push NONE.
    always_comb begin
        push_tag = TagNone;
        if (if_gnt) begin
            push_tag = TagIf;
        end else if (ls_gnt && !ls_we) begin
            push_tag = TagLs;
        end
    end

    mem_bus_arbiter_tag_pipe #(
        .Depth (MEM_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .tag_in  (push_tag),
        .tag_out (out_tag)
    );

    // A fetch response landing in the flush cycle itself is also dropped.
    assign if_rvld  = (out_tag == TagIf) && !flush;
    assign ls_rvld  = (out_tag == TagLs);
    assign if_rdata = if_rvld ? mem_rdata : 32'h0;
    assign ls_rdata = ls_rvld ? mem_rdata : 32'h0;

    assign hold_IF = if_req & ~if_gnt;
    assign hold_EX = ls_req & ~ls_gnt;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall_q;
    logic [31:0] perf_ls_gnt_q;

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_if_stall_q <= 32'h0;
            perf_ls_gnt_q   <= 32'h0;
        end else begin
            if (hold_IF) perf_if_stall_q <= perf_if_stall_q + 32'h1;
            if (ls_gnt)  perf_ls_gnt_q   <= perf_ls_gnt_q + 32'h1;
        end
    end

    assign perf_if_stall = perf_if_stall_q;
    assign perf_ls_gnt   = perf_ls_gnt_q;
`else
    assign perf_if_stall = 32'h0;
    assign perf_ls_gnt   = 32'h0;
`endif

endmodule
